// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: strobe codes, FSM states
// and the access legality check.
package dmem_pkg;

    localparam logic [2:0] STRB_B  = 3'b000;
    localparam logic [2:0] STRB_H  = 3'b001;
    localparam logic [2:0] STRB_W  = 3'b010;
    localparam logic [2:0] STRB_BU = 3'b100;
    localparam logic [2:0] STRB_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } dmem_state_e;

    // Returns 1 when the access must be rejected. Only the two low address
    // bits matter for alignment. Unsigned codes are meaningless for stores.
    function automatic logic dmem_misaligned(input logic [2:0] strb,
                                             input logic [1:0] addr,
                                             input logic       we);
        logic err;
        err = 1'b0;
        if (strb == 3'b011 || strb == 3'b110 || strb == 3'b111) err = 1'b1;
        if (we && strb[2])                                   err = 1'b1;
        if (strb[1:0] == 2'b01 && addr[0])                   err = 1'b1;
        if (strb == STRB_W && addr != 2'b00)                 err = 1'b1;
        return err;
    endfunction

endpackage

// File: rtl/dmem_rr_arb2.sv
// Two-way round-robin grant. A lone requester always wins; on a tie the
// master that was not granted last wins. Output is one-hot or zero.
module dmem_rr_arb2 (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic [1:0] gnt
);

    // Master 0 wins a tie when master 1 was served last, and vice versa.
    always_comb begin
        gnt    = 2'b00;
        gnt[0] = valid[0] & (~valid[1] | last_grant);
        gnt[1] = valid[1] & (~valid[0] | ~last_grant);
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master arbiter/sequencer in front of the byte-addressed data RAM.
// One transaction in flight: IDLE (accept) -> ACCESS (touch RAM) -> RESP.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int AW = 8,
    parameter int DW = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [1:0]          m_req_valid,
    output logic [1:0]          m_req_ready,
    input  logic [1:0]          m_req_we,
    input  logic [1:0][2:0]     m_req_strb,
    input  logic [1:0][AW-1:0]  m_req_addr,
    input  logic [1:0][DW-1:0]  m_req_wdata,
    output logic [1:0]          m_rsp_valid,
    input  logic [1:0]          m_rsp_ready,
    output logic [DW-1:0]       m_rsp_rdata,
    output logic                m_rsp_err,
    output logic                ram_we,
    output logic [2:0]          ram_strb,
    output logic [AW-1:0]       ram_addr,
    output logic [DW-1:0]       ram_wdata,
    input  logic [DW-1:0]       ram_rdata
);

    dmem_state_e   state_q, state_d;
    logic [1:0]    gnt;
    logic          sel;
    logic          accept;
    logic          hs;
    logic          last_grant_q;

    logic          we_q;
    logic [2:0]    strb_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic          owner_q;
    logic          err;

    logic [DW-1:0] rdata_q;
    logic          rerr_q;

    dmem_rr_arb2 u_arb (
        .valid      (m_req_valid),
        .last_grant (last_grant_q),
        .gnt        (gnt)
    );

    assign sel    = gnt[1];
    assign accept = (state_q == IDLE) && (|m_req_valid);
    assign err    = dmem_misaligned(strb_q, addr_q[1:0], we_q);

    // RAM address/strobe/data always reflect the latched request so the RAM
    // never sees a glitch; only the write enable is qualified by state.
    assign ram_strb    = strb_q;
    assign ram_addr    = addr_q;
    assign ram_wdata   = wdata_q;
    assign m_rsp_rdata = rdata_q;
    assign m_rsp_err   = rerr_q;

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next state and handshake outputs. Reset gates the ready and the RAM
    // write combinationally so nothing is accepted or written while it is low.
    always_comb begin
        state_d     = state_q;
        hs          = 1'b0;
        m_req_ready = 2'b00;
        m_rsp_valid = 2'b00;
        ram_we      = 1'b0;
        case (state_q)
            IDLE: begin
                m_req_ready = gnt & {2{reset_n}};
                if (|m_req_valid) state_d = ACCESS;
            end
            ACCESS: begin
                ram_we  = we_q & ~err & reset_n;
                state_d = RESP;
            end
            RESP: begin
                m_rsp_valid[owner_q] = 1'b1;
                if (m_rsp_ready[owner_q]) begin
                    hs      = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Capture the granted master's request; it need not stay stable after.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            we_q    <= 1'b0;
            strb_q  <= 3'b000;
            addr_q  <= '0;
            wdata_q <= '0;
            owner_q <= 1'b0;
        end else if (accept) begin
            we_q    <= m_req_we[sel];
            strb_q  <= m_req_strb[sel];
            addr_q  <= m_req_addr[sel];
            wdata_q <= m_req_wdata[sel];
            owner_q <= sel;
        end
    end

    // Response register: load data only for clean loads, zero otherwise.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rdata_q <= '0;
            rerr_q  <= 1'b0;
        end else if (state_q == ACCESS) begin
            rdata_q <= (!we_q && !err) ? ram_rdata : '0;
            rerr_q  <= err;
        end
    end

    // Round-robin history advances only when a response completes, so a
    // transaction dropped by reset does not count as served.
    always_ff @(posedge clk) begin
        if (!reset_n)  last_grant_q <= 1'b1;
        else if (hs)   last_grant_q <= owner_q;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed table, multi-cycle corner sequences and
// random transactions checked against a byte-array reference model.
module tb_dmem_arbiter;

    logic            clk;
    logic            reset_n;
    logic [1:0]      m_req_valid, m_req_ready, m_req_we;
    logic [1:0][2:0] m_req_strb;
    logic [1:0][7:0] m_req_addr;
    logic [1:0][31:0] m_req_wdata;
    logic [1:0]      m_rsp_valid, m_rsp_ready;
    logic [31:0]     m_rsp_rdata;
    logic            m_rsp_err;
    logic            ram_we;
    logic [2:0]      ram_strb;
    logic [7:0]      ram_addr;
    logic [31:0]     ram_wdata, ram_rdata;

    int nvec = 0;
    int nerr = 0;
    int we_cnt = 0;
    int exp_we = 0;

    dmem_arbiter #(.AW(8), .DW(32)) dut (
        .clk(clk), .reset_n(reset_n),
        .m_req_valid(m_req_valid), .m_req_ready(m_req_ready),
        .m_req_we(m_req_we), .m_req_strb(m_req_strb),
        .m_req_addr(m_req_addr), .m_req_wdata(m_req_wdata),
        .m_rsp_valid(m_rsp_valid), .m_rsp_ready(m_rsp_ready),
        .m_rsp_rdata(m_rsp_rdata), .m_rsp_err(m_rsp_err),
        .ram_we(ram_we), .ram_strb(ram_strb), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- environment RAM (driven by the DUT) ----------------
    logic [7:0] ram [256] = '{default: 8'h00};
    logic [7:0] a1, a2, a3;
    assign a1 = ram_addr + 8'd1;
    assign a2 = ram_addr + 8'd2;
    assign a3 = ram_addr + 8'd3;

    always_comb begin
        case (ram_strb)
            3'b000:  ram_rdata = {{24{ram[ram_addr][7]}}, ram[ram_addr]};
            3'b100:  ram_rdata = {24'h0, ram[ram_addr]};
            3'b001:  ram_rdata = {{16{ram[a1][7]}}, ram[a1], ram[ram_addr]};
            3'b101:  ram_rdata = {16'h0, ram[a1], ram[ram_addr]};
            default: ram_rdata = {ram[a3], ram[a2], ram[a1], ram[ram_addr]};
        endcase
    end

    always @(posedge clk) begin
        if (ram_we) begin
            we_cnt <= we_cnt + 1;
            ram[ram_addr] <= ram_wdata[7:0];
            if (ram_strb[1:0] != 2'b00) ram[a1] <= ram_wdata[15:8];
            if (ram_strb[1:0] == 2'b10) begin
                ram[a2] <= ram_wdata[23:16];
                ram[a3] <= ram_wdata[31:24];
            end
        end
    end

    // ---------------- reference model ----------------
    logic [7:0] ref_mem [256] = '{default: 8'h00};

    function automatic int ref_size(logic [2:0] s);
        if (s[1:0] == 2'b00) return 1;
        if (s[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic ref_err(logic we, logic [2:0] s, logic [7:0] a);
        if (!(s inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) return 1'b1;
        if (we && s[2]) return 1'b1;
        return (int'(a) % ref_size(s)) != 0;
    endfunction

    function automatic logic [31:0] ref_load(logic [2:0] s, logic [7:0] a);
        int sz;
        logic [31:0] v;
        sz = ref_size(s);
        v  = 32'h0;
        for (int i = 0; i < sz; i++) v = v | (32'(ref_mem[8'(int'(a) + i)]) << (8 * i));
        if (!s[2] && sz < 4 && v[8 * sz - 1]) v = v | ~((32'd1 << (8 * sz)) - 32'd1);
        return v;
    endfunction

    task automatic ref_store(logic [2:0] s, logic [7:0] a, logic [31:0] d);
        for (int i = 0; i < ref_size(s); i++) ref_mem[8'(int'(a) + i)] = 8'(d >> (8 * i));
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, "_req_ready"}, 32'(m_req_ready), 32'd0);
        chk({nm, "_rsp_valid"}, 32'(m_rsp_valid), 32'd0);
        chk({nm, "_rdata"},     m_rsp_rdata,      32'd0);
        chk({nm, "_err"},       32'(m_rsp_err),   32'd0);
        chk({nm, "_ram_we"},    32'(ram_we),      32'd0);
        chk({nm, "_ram_addr"},  32'(ram_addr),    32'd0);
        chk({nm, "_ram_strb"},  32'(ram_strb),    32'd0);
        chk({nm, "_ram_wdata"}, ram_wdata,        32'd0);
    endtask

    // One full transaction from IDLE, called just after a falling edge.
    // Checks accept, the N+1 RAM cycle, the N+2 response and its hold under
    // bp cycles of backpressure, then returns in IDLE.
    task automatic txn(input int m, input logic we, input logic [2:0] s,
                       input logic [7:0] a, input logic [31:0] d, input int bp,
                       input logic [31:0] exp_rd, input logic exp_er, input string nm);
        int k;
        logic model_err;
        model_err = ref_err(we, s, a);
        m_req_valid[m] = 1'b1;
        m_req_we[m]    = we;
        m_req_strb[m]  = s;
        m_req_addr[m]  = a;
        m_req_wdata[m] = d;
        m_rsp_ready[m] = (bp == 0);
        k = 0;
        #1;
        while (m_req_ready[m] !== 1'b1 && k < 10) begin
            @(negedge clk); #1; k++;
        end
        chk({nm, "_accept"}, 32'(m_req_ready), 32'(2'b01 << m));
        @(negedge clk);
        m_req_valid[m] = 1'b0;
        #1;
        chk({nm, "_ram_we"},   32'(ram_we),      32'(we & ~exp_er));
        chk({nm, "_ram_addr"}, 32'(ram_addr),    32'(a));
        chk({nm, "_ram_strb"}, 32'(ram_strb),    32'(s));
        chk({nm, "_ram_wd"},   ram_wdata,        d);
        chk({nm, "_early"},    32'(m_rsp_valid), 32'd0);
        @(negedge clk); #1;
        chk({nm, "_rsp_valid"}, 32'(m_rsp_valid), 32'(2'b01 << m));
        chk({nm, "_rdata"},     m_rsp_rdata,      exp_rd);
        chk({nm, "_err"},       32'(m_rsp_err),   32'(exp_er));
        chk({nm, "_we_off"},    32'(ram_we),      32'd0);
        for (int i = 0; i < bp; i++) begin
            @(negedge clk); #1;
            chk({nm, "_hold_v"}, 32'(m_rsp_valid), 32'(2'b01 << m));
            chk({nm, "_hold_d"}, m_rsp_rdata,      exp_rd);
            chk({nm, "_hold_e"}, 32'(m_rsp_err),   32'(exp_er));
        end
        m_rsp_ready[m] = 1'b1;
        @(negedge clk); #1;
        chk({nm, "_done"}, 32'(m_rsp_valid), 32'd0);
        m_rsp_ready[m] = 1'b0;
        if (we && !model_err) begin
            ref_store(s, a, d);
            exp_we++;
        end
    endtask

    // Transaction whose expectations come from the reference model.
    task automatic mtxn(input int m, input logic we, input logic [2:0] s,
                        input logic [7:0] a, input logic [31:0] d, input int bp,
                        input string nm);
        logic e;
        e = ref_err(we, s, a);
        txn(m, we, s, a, d, bp, (we || e) ? 32'h0 : ref_load(s, a), e, nm);
    endtask

    typedef struct {
        int          m;
        logic        we;
        logic [2:0]  s;
        logic [7:0]  a;
        logic [31:0] d;
        int          bp;
        logic [31:0] rd;
        logic        er;
        string       nm;
    } vec_t;

    vec_t tbl [15];
    int   gm [4];
    int   gc [4];
    int   ng;

    initial begin
        tbl[0]  = '{0, 1'b1, 3'b010, 8'h10, 32'hDEADBEEF, 0, 32'h00000000, 1'b0, "st_w10"};
        tbl[1]  = '{0, 1'b0, 3'b010, 8'h10, 32'h0,        0, 32'hDEADBEEF, 1'b0, "ld_w10"};
        tbl[2]  = '{0, 1'b1, 3'b000, 8'h20, 32'h00000080, 0, 32'h00000000, 1'b0, "st_b20"};
        tbl[3]  = '{0, 1'b0, 3'b000, 8'h20, 32'h0,        0, 32'hFFFFFF80, 1'b0, "ld_b20"};
        tbl[4]  = '{0, 1'b0, 3'b100, 8'h20, 32'h0,        0, 32'h00000080, 1'b0, "ld_bu20"};
        tbl[5]  = '{0, 1'b1, 3'b010, 8'h21, 32'hCAFEF00D, 0, 32'h00000000, 1'b1, "st_w21"};
        tbl[6]  = '{0, 1'b0, 3'b001, 8'h33, 32'h0,        0, 32'h00000000, 1'b1, "ld_h33"};
        tbl[7]  = '{0, 1'b1, 3'b100, 8'h20, 32'h00000055, 0, 32'h00000000, 1'b1, "st_bu20"};
        tbl[8]  = '{0, 1'b0, 3'b010, 8'h20, 32'h0,        0, 32'h00000080, 1'b0, "ld_w20"};
        tbl[9]  = '{1, 1'b1, 3'b001, 8'h30, 32'h12348001, 0, 32'h00000000, 1'b0, "m1_st_h30"};
        tbl[10] = '{0, 1'b0, 3'b001, 8'h30, 32'h0,        0, 32'hFFFF8001, 1'b0, "ld_h30"};
        tbl[11] = '{1, 1'b0, 3'b101, 8'h30, 32'h0,        0, 32'h00008001, 1'b0, "m1_ld_hu30"};
        tbl[12] = '{0, 1'b1, 3'b011, 8'h40, 32'h0BADF00D, 0, 32'h00000000, 1'b1, "st_011"};
        tbl[13] = '{1, 1'b0, 3'b111, 8'h40, 32'h0,        0, 32'h00000000, 1'b1, "ld_111"};
        tbl[14] = '{0, 1'b0, 3'b010, 8'h10, 32'h0,        3, 32'hDEADBEEF, 1'b0, "ld_w10_bp"};

        reset_n     = 1'b0;
        m_req_valid = 2'b00;
        m_req_we    = 2'b00;
        m_req_strb  = '0;
        m_req_addr  = '0;
        m_req_wdata = '0;
        m_rsp_ready = 2'b00;
        repeat (3) @(negedge clk);
        #1;
        chk_reset("rst");

        // Tie arbitration: both masters loading from reset, responses always taken.
        m_req_we    = 2'b00;
        m_req_strb  = {3'b010, 3'b010};
        m_req_addr  = {8'h14, 8'h10};
        m_req_valid = 2'b11;
        m_rsp_ready = 2'b11;
        #1;
        chk("tie_in_reset", 32'(m_req_ready), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        ng = 0;
        for (int c = 0; c < 20 && ng < 4; c++) begin
            #1;
            if (m_req_ready != 2'b00) begin
                chk("tie_onehot", 32'($onehot(m_req_ready)), 32'd1);
                gm[ng] = int'(m_req_ready[1]);
                gc[ng] = c;
                ng++;
            end
            @(negedge clk);
        end
        m_req_valid = 2'b00;
        repeat (3) @(negedge clk);
        m_rsp_ready = 2'b00;
        chk("tie_count", 32'(ng), 32'd4);
        for (int i = 0; i < ng; i++) chk("tie_grant", 32'(gm[i]), 32'(i % 2));
        for (int i = 1; i < ng; i++) chk("tie_spacing", 32'(gc[i] - gc[i-1]), 32'd3);

        // Directed table.
        #1;
        for (int i = 0; i < 15; i++)
            txn(tbl[i].m, tbl[i].we, tbl[i].s, tbl[i].a, tbl[i].d, tbl[i].bp,
                tbl[i].rd, tbl[i].er, tbl[i].nm);

        // Response backpressure on m1 while m0 waits.
        m_req_valid[1] = 1'b1; m_req_we[1] = 1'b0; m_req_strb[1] = 3'b010;
        m_req_addr[1]  = 8'h10; m_rsp_ready[1] = 1'b0;
        #1;
        chk("bp_accept1", 32'(m_req_ready), 32'h2);
        @(negedge clk);
        m_req_valid[1] = 1'b0;
        m_req_valid[0] = 1'b1; m_req_we[0] = 1'b0; m_req_strb[0] = 3'b010;
        m_req_addr[0]  = 8'h20; m_rsp_ready[0] = 1'b1;
        #1;
        chk("bp_busy", 32'(m_req_ready), 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            chk("bp_valid", 32'(m_rsp_valid), 32'h2);
            chk("bp_rdata", m_rsp_rdata,      32'hDEADBEEF);
            chk("bp_err",   32'(m_rsp_err),   32'd0);
            chk("bp_noacc", 32'(m_req_ready), 32'd0);
        end
        m_rsp_ready[1] = 1'b1;
        @(negedge clk); #1;
        chk("bp_m0_next", 32'(m_req_ready), 32'h1);
        chk("bp_released", 32'(m_rsp_valid), 32'd0);
        @(negedge clk);
        m_req_valid[0] = 1'b0;
        @(negedge clk); #1;
        chk("bp_m0_rsp", 32'(m_rsp_valid), 32'h1);
        chk("bp_m0_rd",  m_rsp_rdata,      32'h00000080);
        @(negedge clk);
        m_rsp_ready = 2'b00;

        // Reset during ACCESS of a store: write suppressed, no response.
        #1;
        mtxn(0, 1'b1, 3'b010, 8'h40, 32'h11111111, 0, "pre40");
        m_req_valid[0] = 1'b1; m_req_we[0] = 1'b1; m_req_strb[0] = 3'b010;
        m_req_addr[0]  = 8'h40; m_req_wdata[0] = 32'h22222222; m_rsp_ready[0] = 1'b1;
        #1;
        chk("rsta_accept", 32'(m_req_ready), 32'h1);
        @(negedge clk);
        reset_n     = 1'b0;
        m_req_valid = 2'b00;
        #1;
        chk("rsta_we_gated", 32'(ram_we), 32'd0);
        @(negedge clk); #1;
        chk_reset("rsta");
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk); #1;
        chk("rsta_norsp", 32'(m_rsp_valid), 32'd0);
        m_rsp_ready = 2'b00;
        mtxn(0, 1'b0, 3'b010, 8'h40, 32'h0, 0, "post40");
        chk("rsta_mem", {ram[8'h43], ram[8'h42], ram[8'h41], ram[8'h40]}, 32'h11111111);

        // Reset while a response is pending: valid drops at the next edge.
        m_req_valid[1] = 1'b1; m_req_we[1] = 1'b0; m_req_strb[1] = 3'b010;
        m_req_addr[1]  = 8'h40; m_rsp_ready[1] = 1'b0;
        #1;
        chk("rstr_accept", 32'(m_req_ready), 32'h2);
        @(negedge clk);
        m_req_valid[1] = 1'b0;
        @(negedge clk); #1;
        chk("rstr_valid", 32'(m_rsp_valid), 32'h2);
        reset_n = 1'b0;
        @(negedge clk); #1;
        chk("rstr_drop", 32'(m_rsp_valid), 32'd0);
        reset_n = 1'b1;
        @(negedge clk); #1;

        // Random single-master traffic against the reference model.
        for (int i = 0; i < 40; i++)
            mtxn(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 3'($urandom_range(0, 7)), 8'h80 + 8'($urandom_range(0, 15)),
                 $urandom, int'($urandom_range(0, 2)), "rnd");

        @(negedge clk);
        chk("write_count", 32'(we_cnt), 32'(exp_we));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
